// File: rtl/aes_serial_host_if.sv
// Parallel host-side bus of aes_serial_host: key and plaintext requests in,
// ciphertext and status out. The host/bus side uses master, the endpoint uses slave.
interface aes_serial_host_if;
    logic [127:0] key;
    logic         key_load;
    logic [127:0] pt;
    logic         pt_valid;
    logic         pt_ready;
    logic [127:0] ct;
    logic         ct_valid;
    logic         busy;
    logic         err;

    modport master (
        output key, key_load, pt, pt_valid,
        input  pt_ready, ct, ct_valid, busy, err
    );

    modport slave (
        input  key, key_load, pt, pt_valid,
        output pt_ready, ct, ct_valid, busy, err
    );
endinterface

// File: rtl/aes_serial_host.sv
// aes_serial_host: bit-serial bridge between a parallel key/plaintext bus and the AES-128 core pins.
// Optional WAIT-state timeout (parameter TIMEOUT) is compiled in when HOST_TIMEOUT_EN is defined.
module aes_serial_host #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    aes_serial_host_if.slave bus,
    output logic             K_IN,
    output logic             DIN,
    output logic             EN,
    input  logic             DOUT,
    input  logic             OUT_VAL
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KEY  = 2'd1,
        ST_DATA = 2'd2,
        ST_WAIT = 2'd3
    } state_e;

    // The wait counter compares against TIMEOUT-1 and needs room for a full frame.
    if (TIMEOUT < 130) begin : g_timeout_range
        $error("aes_serial_host: TIMEOUT must be at least 130");
    end

    state_e       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [127:0] sr_q, sr_d;
    logic         key_ok_q, key_ok_d;
    logic [127:0] ct_q, ct_d;
    logic         k_in_q, k_in_d;
    logic         din_q, din_d;
    logic         en_q, en_d;
    logic         pt_ready_q, pt_ready_d;
    logic         ct_valid_q, ct_valid_d;
    logic         busy_q, busy_d;
    logic         err_q, err_d;
`ifdef HOST_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    logic [15:0]  wait_q, wait_d;
`endif

    // Next-state and next-output logic; one shift register serves key, plaintext and capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        key_ok_d   = key_ok_q;
        ct_d       = ct_q;
        k_in_d     = 1'b0;
        din_d      = 1'b0;
        en_d       = 1'b0;
        ct_valid_d = 1'b0;
        err_d      = 1'b0;
`ifdef HOST_TIMEOUT_EN
        wait_d     = wait_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // key_load withholds plaintext acceptance even while pt_ready is shown high.
                if (bus.key_load) begin
                    sr_d    = bus.key;
                    cnt_d   = 8'd0;
                    k_in_d  = 1'b1;
                    state_d = ST_KEY;
                end else if (bus.pt_valid && pt_ready_q) begin
                    sr_d    = {bus.pt[126:0], 1'b0};
                    din_d   = bus.pt[127];
                    en_d    = 1'b1;
                    cnt_d   = 8'd1;
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_KEY: begin
                if (cnt_q == 8'd128) begin
                    key_ok_d = 1'b1;
                    cnt_d    = 8'd0;
                    state_d  = ST_IDLE;
                end else begin
                    k_in_d = sr_q[127];
                    sr_d   = {sr_q[126:0], 1'b0};
                    cnt_d  = cnt_q + 8'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == 8'd128) begin
                    cnt_d   = 8'd0;
                    state_d = ST_WAIT;
`ifdef HOST_TIMEOUT_EN
                    wait_d  = 16'd0;
`endif
                end else begin
                    din_d = sr_q[127];
                    en_d  = 1'b1;
                    sr_d  = {sr_q[126:0], 1'b0};
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WAIT: begin
`ifdef HOST_TIMEOUT_EN
                wait_d = wait_q + 16'd1;
`endif
                if (OUT_VAL) begin
                    sr_d  = {sr_q[126:0], DOUT};
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q;
                end
                // Completion is tested first so it wins over a same-cycle timeout.
                if (OUT_VAL && (cnt_q == 8'd127)) begin
                    ct_d       = sr_d;
                    ct_valid_d = 1'b1;
                    cnt_d      = 8'd0;
                    state_d    = ST_IDLE;
                end
`ifdef HOST_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = 8'd0;
                    sr_d    = 128'd0;
                    state_d = ST_IDLE;
                end
`endif
                else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        pt_ready_d = (state_d == ST_IDLE) && key_ok_d;
        busy_d     = (state_d != ST_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            sr_q       <= 128'd0;
            key_ok_q   <= 1'b0;
            ct_q       <= 128'd0;
            k_in_q     <= 1'b0;
            din_q      <= 1'b0;
            en_q       <= 1'b0;
            pt_ready_q <= 1'b0;
            ct_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef HOST_TIMEOUT_EN
            wait_q     <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            key_ok_q   <= key_ok_d;
            ct_q       <= ct_d;
            k_in_q     <= k_in_d;
            din_q      <= din_d;
            en_q       <= en_d;
            pt_ready_q <= pt_ready_d;
            ct_valid_q <= ct_valid_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
`ifdef HOST_TIMEOUT_EN
            wait_q     <= wait_d;
`endif
        end
    end

    assign K_IN         = k_in_q;
    assign DIN          = din_q;
    assign EN           = en_q;
    assign bus.pt_ready = pt_ready_q;
    assign bus.ct       = ct_q;
    assign bus.ct_valid = ct_valid_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_aes_serial_host.sv
// Self-checking bench for aes_serial_host: vector table plus scoreboard queues for the
// plaintext bit stream and the returned ciphertext, and hand-written corner sequences.
module tb_aes_serial_host;

`ifdef HOST_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 200;
`else
    localparam int unsigned TB_TIMEOUT = 1024;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic K_IN, DIN, EN;
    logic DOUT = 1'b0;
    logic OUT_VAL = 1'b0;

    aes_serial_host_if bus_if();

    aes_serial_host #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if),
        .K_IN    (K_IN),
        .DIN     (DIN),
        .EN      (EN),
        .DOUT    (DOUT),
        .OUT_VAL (OUT_VAL)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] resp;
        bit           gapped;
        int           lat;
        logic [127:0] exp_ct;
    } vec_t;

    vec_t         vecs [3];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [127:0] exp_pt_q [$];
    logic [127:0] exp_ct_q [$];

    localparam logic [127:0] K4 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] P4 = 128'hfedcba9876543210_0123456789abcdef;
    localparam logic [127:0] R4 = 128'h00000000_00000000_00000000_00000001;
    localparam logic [127:0] P5 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] R5 = 128'hdeadbeef_0badf00d_cafef00d_12345678;
    localparam logic [127:0] P6 = 128'ha5a5a5a5_5a5a5a5a_a5a5a5a5_5a5a5a5a;

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", nm, got, exp);
        end
    endtask

    task automatic chk128(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic chkint(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Issue key_load (optionally with pt_valid in the same cycle) and check the K_IN frame.
    task automatic load_key(input logic [127:0] k, input bit with_pt, input logic [127:0] p);
        logic [127:0] got;
        logic         start_bit;
        int           bad;
        got = '0;
        start_bit = 1'b0;
        bad = 0;
        @(posedge clk);
        #1;
        bus_if.key = k;
        bus_if.key_load = 1'b1;
        if (with_pt) begin
            bus_if.pt = p;
            bus_if.pt_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        bus_if.key_load = 1'b0;
        bus_if.key = '0;
        for (int i = 1; i <= 129; i++) begin
            @(negedge clk);
            if (i == 1) start_bit = K_IN;
            else got[129 - i] = K_IN;
            if (!bus_if.busy || bus_if.pt_ready || EN) bad++;
        end
        @(negedge clk);
        chk1("key_start_bit", start_bit, 1'b1);
        chk128("key_bits", got, k);
        chkint("key_busy_window", bad, 0);
        chk1("pt_ready_at_130", bus_if.pt_ready, 1'b1);
        chk1("busy_low_at_130", bus_if.busy, 1'b0);
        chk1("k_in_idle_at_130", K_IN, 1'b0);
    endtask

    // Offer a plaintext from a cycle with pt_ready high and watch nb bits of the DIN frame.
    task automatic send_pt(input logic [127:0] p, input int nb);
        logic [127:0] got;
        int           bad;
        got = '0;
        bad = 0;
        chk1("pt_ready_before_accept", bus_if.pt_ready, 1'b1);
        bus_if.pt = p;
        bus_if.pt_valid = 1'b1;
        exp_pt_q.push_back(p);
        @(posedge clk);
        #1;
        bus_if.pt_valid = 1'b0;
        bus_if.pt = '0;
        for (int i = 1; i <= nb; i++) begin
            @(negedge clk);
            got[128 - i] = DIN;
            if (!EN || !bus_if.busy || bus_if.pt_ready) bad++;
            OUT_VAL = 1'($urandom_range(0, 1));
            DOUT = 1'($urandom_range(0, 1));
        end
        chkint("en_frame_window", bad, 0);
        if (nb == 128) begin
            @(negedge clk);
            OUT_VAL = 1'b0;
            DOUT = 1'b0;
            chk1("en_low_after_frame", EN, 1'b0);
            chk1("din_low_after_frame", DIN, 1'b0);
            chk1("busy_in_wait", bus_if.busy, 1'b1);
            chkint("pt_scoreboard_depth", exp_pt_q.size(), 1);
            if (exp_pt_q.size() != 0) chk128("din_frame", got, exp_pt_q.pop_front());
        end
    endtask

    // Core model: return count bits of val starting at bit index first, MSB first.
    task automatic drive_bits(input logic [127:0] val, input int first, input int count,
                              input bit gapped, input int lat);
        int b, j, early;
        b = first;
        j = 0;
        early = 0;
        for (int i = 0; i < lat; i++) begin
            @(posedge clk);
            #1;
            OUT_VAL = 1'b0;
            DOUT = 1'($urandom_range(0, 1));
        end
        while (b < first + count) begin
            @(posedge clk);
            #1;
            if (gapped && (j % 3 == 2)) begin
                OUT_VAL = 1'b0;
                DOUT = 1'($urandom_range(0, 1));
            end else begin
                OUT_VAL = 1'b1;
                DOUT = val[127 - b];
                b++;
            end
            j++;
            @(negedge clk);
            if (bus_if.ct_valid || bus_if.err || !bus_if.busy) early++;
        end
        @(posedge clk);
        #1;
        OUT_VAL = 1'b0;
        DOUT = 1'b0;
        chkint("wait_no_early_result", early, 0);
    endtask

    // Expect the result in the cycle after the last returned bit.
    task automatic check_result();
        @(negedge clk);
        chk1("ct_valid_pulse", bus_if.ct_valid, 1'b1);
        chk1("busy_low_with_ct", bus_if.busy, 1'b0);
        chk1("pt_ready_with_ct", bus_if.pt_ready, 1'b1);
        chk1("err_low_with_ct", bus_if.err, 1'b0);
        chkint("ct_scoreboard_depth", exp_ct_q.size(), 1);
        if (exp_ct_q.size() != 0) chk128("ct_value", bus_if.ct, exp_ct_q.pop_front());
        @(negedge clk);
        chk1("ct_valid_single", bus_if.ct_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the test sequence ended");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, err_first, err_cnt;
        vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32, 1'b1, 2,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 5,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{128'hffffffff_ffffffff_ffffffff_ffffffff, 128'h80000000_00000000_00000000_00000001,
                    128'h01234567_89abcdef_fedcba98_76543210, 1'b1, 0,
                    128'h01234567_89abcdef_fedcba98_76543210};

        bus_if.key = '0;
        bus_if.key_load = 1'b0;
        bus_if.pt = '0;
        bus_if.pt_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk128("reset_flags", {121'd0, K_IN, DIN, EN, bus_if.pt_ready, bus_if.ct_valid,
                               bus_if.busy, bus_if.err}, 128'd0);
        chk128("reset_ct", bus_if.ct, 128'd0);
        reset_n = 1'b1;

        // Plaintext offered before any key: never accepted.
        bus_if.pt = vecs[0].pt;
        bus_if.pt_valid = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_if.pt_ready || EN || bus_if.busy) bad++;
        end
        chkint("no_accept_before_key", bad, 0);
        bus_if.pt_valid = 1'b0;

        for (int v = 0; v < 3; v++) begin
            load_key(vecs[v].key, 1'b0, 128'd0);
            send_pt(vecs[v].pt, 128);
            exp_ct_q.push_back(vecs[v].exp_ct);
            drive_bits(vecs[v].resp, 0, 128, vecs[v].gapped, vecs[v].lat);
            check_result();
        end

        // key_load and pt_valid together: key wins, pt taken on the first IDLE cycle after.
        load_key(K4, 1'b1, P4);
        send_pt(P4, 128);
        exp_ct_q.push_back(R4);
        drive_bits(R4, 0, 128, 1'b0, 1);
        check_result();

        // Core returns only 100 bits.
        send_pt(P5, 128);
`ifdef HOST_TIMEOUT_EN
        err_first = 0;
        err_cnt = 0;
        bad = 0;
        for (int k = 2; k <= 205; k++) begin
            @(posedge clk);
            #1;
            if (k <= 101) begin
                OUT_VAL = 1'b1;
                DOUT = R5[127 - (k - 2)];
            end else begin
                OUT_VAL = 1'b0;
                DOUT = 1'b0;
            end
            @(negedge clk);
            if (bus_if.err) begin
                err_cnt++;
                if (err_first == 0) err_first = k;
            end
            if (bus_if.ct_valid) bad++;
            if (k == 201) begin
                chk1("timeout_pt_ready", bus_if.pt_ready, 1'b1);
                chk1("timeout_busy_low", bus_if.busy, 1'b0);
                chk128("timeout_ct_unchanged", bus_if.ct, R4);
            end
        end
        chkint("timeout_err_cycle", err_first, 201);
        chkint("timeout_err_pulses", err_cnt, 1);
        chkint("timeout_no_ct_valid", bad, 0);
`else
        err_first = 0;
        err_cnt = 0;
        bad = 0;
        for (int k = 2; k <= 300; k++) begin
            @(posedge clk);
            #1;
            if (k <= 101) begin
                OUT_VAL = 1'b1;
                DOUT = R5[127 - (k - 2)];
            end else begin
                OUT_VAL = 1'b0;
                DOUT = 1'b0;
            end
            @(negedge clk);
            if (bus_if.err) err_cnt++;
            if (bus_if.ct_valid || !bus_if.busy || bus_if.pt_ready) bad++;
        end
        chkint("wait_persists", bad, 0);
        chkint("err_tied_low", err_cnt, 0);
        chk128("ct_held_in_wait", bus_if.ct, R4);
        exp_ct_q.push_back(R5);
        drive_bits(R5, 100, 28, 1'b0, 0);
        check_result();
`endif

        // Reset in the middle of a plaintext frame (after bit 60).
        send_pt(P6, 60);
        reset_n = 1'b0;
        OUT_VAL = 1'b0;
        #1;
        chk128("midreset_flags", {121'd0, K_IN, DIN, EN, bus_if.pt_ready, bus_if.ct_valid,
                                  bus_if.busy, bus_if.err}, 128'd0);
        chk128("midreset_ct", bus_if.ct, 128'd0);
        if (exp_pt_q.size() != 0) void'(exp_pt_q.pop_front());
        @(negedge clk);
        reset_n = 1'b1;
        bus_if.pt = P6;
        bus_if.pt_valid = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_if.pt_ready || EN || bus_if.busy) bad++;
        end
        chkint("key_ok_cleared_by_reset", bad, 0);
        bus_if.pt_valid = 1'b0;

        load_key(vecs[0].key, 1'b0, 128'd0);
        send_pt(vecs[0].pt, 128);
        exp_ct_q.push_back(vecs[0].exp_ct);
        drive_bits(vecs[0].resp, 0, 128, 1'b0, 0);
        check_result();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
